// File: rtl/restoring_divider_n.sv
// Multi-cycle unsigned restoring divider: one quotient bit per CALC cycle, WIDTH cycles per operation.
// Optional DIVZERO_DETECT_EN macro adds a one-cycle divide-by-zero fast path (DZERO state).
module restoring_divider_n #(
   parameter  int WIDTH = 4,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in_1,
   input  logic [WIDTH-1:0] data_in_2,
   output logic [2:0]       p_STATE,
   output logic [WIDTH-1:0] o_reg_Q,
   output logic [WIDTH-1:0] o_reg_R,
   output logic [WIDTH-1:0] o_reg_B,
   output logic [CNT_W-1:0] Count_out,
   output logic             done,
   output logic             busy,
   output logic             div_zero
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CALC  = 3'd1,
`ifdef DIVZERO_DETECT_EN
      DZERO = 3'd3,
`endif
      DONE  = 3'd2
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [2*WIDTH-1:0]   rq_sh;
   logic [WIDTH:0]       trial;

   assign p_STATE = state;

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = IDLE;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
`ifdef DIVZERO_DETECT_EN
               state_nxt = (data_in_1 == '0) ? DZERO : CALC;
`else
               state_nxt = CALC;
`endif
            end
         end
         CALC: begin
            busy      = 1'b1;
            state_nxt = (Count_out == CNT_W'(1)) ? DONE : CALC;
         end
`ifdef DIVZERO_DETECT_EN
         DZERO: begin
            busy      = 1'b1;
            state_nxt = DONE;
         end
`endif
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Trial subtraction is one bit wider than the operands; its MSB is the borrow (negative result).
   always_comb begin
      rq_sh = {o_reg_R, o_reg_Q} << 1;
      trial = {1'b0, rq_sh[2*WIDTH-1:WIDTH]} - {1'b0, o_reg_B};
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_reg_Q   <= '0;
         o_reg_R   <= '0;
         o_reg_B   <= '0;
         Count_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  o_reg_B   <= data_in_1;
                  o_reg_Q   <= data_in_2;
                  o_reg_R   <= '0;
                  Count_out <= CNT_W'(WIDTH);
               end
            end
            CALC: begin
               Count_out <= Count_out - CNT_W'(1);
               if (trial[WIDTH]) begin
                  o_reg_R <= rq_sh[2*WIDTH-1:WIDTH];
                  o_reg_Q <= {rq_sh[WIDTH-1:1], 1'b0};
               end else begin
                  o_reg_R <= trial[WIDTH-1:0];
                  o_reg_Q <= {rq_sh[WIDTH-1:1], 1'b1};
               end
            end
`ifdef DIVZERO_DETECT_EN
            DZERO: begin
               // The dividend was parked in Q at acceptance; it becomes the remainder.
               o_reg_R   <= o_reg_Q;
               o_reg_Q   <= '1;
               o_reg_B   <= '0;
               Count_out <= '0;
            end
`endif
            default: ;
         endcase
      end
   end

   // done is registered off DONE, so it pulses on the IDLE cycle that follows it.
   always_ff @(posedge i_clk) begin
      if (i_rst) done <= 1'b0;
      else       done <= (state == DONE);
   end

`ifdef DIVZERO_DETECT_EN
   logic dz_r;
   always_ff @(posedge i_clk) begin
      if (i_rst)                     dz_r <= 1'b0;
      else if (state == IDLE && start) dz_r <= 1'b0;
      else if (state == DZERO)       dz_r <= 1'b1;
   end
   assign div_zero = dz_r;
`else
   assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_restoring_divider_n.sv
// Bench for restoring_divider_n: vector table, hand-written corner sequences and random operands
// checked against an arithmetic model (WIDTH=4 and WIDTH=8 instances).
module tb_restoring_divider_n;

   localparam int W  = 4;
   localparam int W8 = 8;
`ifdef DIVZERO_DETECT_EN
   localparam bit DZ_EN = 1'b1;
`else
   localparam bit DZ_EN = 1'b0;
`endif

   // clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic         start;
   logic [W-1:0] data_in_1, data_in_2;
   logic [2:0]   p_state;
   logic [W-1:0] reg_q, reg_r, reg_b;
   logic [2:0]   count_out;
   logic         done, busy, div_zero;

   logic          start8;
   logic [W8-1:0] b8, a8;
   logic [2:0]    p_state8;
   logic [W8-1:0] reg_q8, reg_r8, reg_b8;
   logic [3:0]    count_out8;
   logic          done8, busy8, div_zero8;

   restoring_divider_n #(.WIDTH(W)) dut (
      .i_clk(clk), .i_rst(rst), .start(start), .data_in_1(data_in_1), .data_in_2(data_in_2),
      .p_STATE(p_state), .o_reg_Q(reg_q), .o_reg_R(reg_r), .o_reg_B(reg_b),
      .Count_out(count_out), .done(done), .busy(busy), .div_zero(div_zero)
   );

   restoring_divider_n #(.WIDTH(W8)) dut8 (
      .i_clk(clk), .i_rst(rst), .start(start8), .data_in_1(b8), .data_in_2(a8),
      .p_STATE(p_state8), .o_reg_Q(reg_q8), .o_reg_R(reg_r8), .o_reg_B(reg_b8),
      .Count_out(count_out8), .done(done8), .busy(busy8), .div_zero(div_zero8)
   );

   int checks = 0;
   int errors = 0;
   logic [2*W-1:0] exp_q[$];

   typedef struct {
      logic [W-1:0] b;
      logic [W-1:0] a;
      logic [W-1:0] q;
      logic [W-1:0] r;
   } vec_t;
   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain integer division; B=0 yields all-ones quotient, dividend remainder.
   task automatic model(input logic [W-1:0] b, input logic [W-1:0] a,
                        output logic [W-1:0] q, output logic [W-1:0] r);
      if (b == 0) begin
         q = '1;
         r = a;
      end else begin
         q = a / b;
         r = a % b;
      end
   endtask

   // driver + checker for one WIDTH=4 operation; called with the DUT in IDLE, #1 after an edge
   task automatic do_div(input logic [W-1:0] b, input logic [W-1:0] a,
                         input logic [W-1:0] eq, input logic [W-1:0] er);
      logic [2*W-1:0] e;
      bit  edz;
      int  elat, lat, got;
      edz  = (b == 0) && DZ_EN;
      elat = edz ? 2 : W + 1;
      exp_q.push_back({eq, er});
      start = 1'b1; data_in_1 = b; data_in_2 = a;
      @(posedge clk); #1;
      start = 1'b0;
      chk("state_after_accept", 32'(p_state), edz ? 32'd3 : 32'd1);
      chk("busy_after_accept", 32'(busy), 32'd1);
      if (!edz) chk("count_load", 32'(count_out), 32'(W));
      got = 0; lat = 0;
      for (int i = 1; i <= 30; i++) begin
         @(posedge clk); #1;
         if (done) begin
            got = 1; lat = i;
            break;
         end
         if (!edz && i < W) chk("count_calc", 32'(count_out), 32'(W - i));
      end
      chk("done_seen", 32'(got), 32'd1);
      e = exp_q.pop_front();
      chk("latency", 32'(lat), 32'(elat));
      chk("quotient", 32'(reg_q), 32'(e[2*W-1:W]));
      chk("remainder", 32'(reg_r), 32'(e[W-1:0]));
      chk("div_zero", 32'(div_zero), 32'(edz));
      chk("count_done", 32'(count_out), 32'd0);
      chk("busy_done", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("div_zero_hold", 32'(div_zero), 32'(edz));
   endtask

   task automatic div8(input logic [W8-1:0] b, input logic [W8-1:0] a);
      logic [W8-1:0] eq, er;
      int got, lat;
      eq = (b == 0) ? '1 : a / b;
      er = (b == 0) ? a : a % b;
      start8 = 1'b1; b8 = b; a8 = a;
      @(posedge clk); #1;
      start8 = 1'b0;
      got = 0; lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (done8) begin
            got = 1; lat = i;
            break;
         end
      end
      chk("w8_done_seen", 32'(got), 32'd1);
      if (b != 0 || !DZ_EN) chk("w8_latency", 32'(lat), 32'd9);
      chk("w8_quotient", 32'(reg_q8), 32'(eq));
      chk("w8_remainder", 32'(reg_r8), 32'(er));
   endtask

   initial begin
      int first, second, npulses, got;
      logic [W-1:0] rb, ra, mq, mr;

      vecs[0] = '{4'd2,  4'd15, 4'd7,  4'd1};
      vecs[1] = '{4'd1,  4'd0,  4'd0,  4'd0};
      vecs[2] = '{4'd15, 4'd15, 4'd1,  4'd0};
      vecs[3] = '{4'd3,  4'd10, 4'd3,  4'd1};
      vecs[4] = '{4'd5,  4'd4,  4'd0,  4'd4};
      vecs[5] = '{4'd1,  4'd15, 4'd15, 4'd0};
      vecs[6] = '{4'd0,  4'd15, 4'd15, 4'd15};
      vecs[7] = '{4'd15, 4'd14, 4'd0,  4'd14};
      vecs[8] = '{4'd7,  4'd0,  4'd0,  4'd0};

      rst = 1'b1; start = 1'b0; data_in_1 = '0; data_in_2 = '0;
      start8 = 1'b0; b8 = '0; a8 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", 32'(p_state), 32'd0);
      chk("rst_q", 32'(reg_q), 32'd0);
      chk("rst_r", 32'(reg_r), 32'd0);
      chk("rst_b", 32'(reg_b), 32'd0);
      chk("rst_count", 32'(count_out), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_div_zero", 32'(div_zero), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) do_div(vecs[i].b, vecs[i].a, vecs[i].q, vecs[i].r);

      // reset during the second CALC cycle aborts the operation
      start = 1'b1; data_in_1 = 4'd5; data_in_2 = 4'd13;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_state", 32'(p_state), 32'd0);
      chk("abort_q", 32'(reg_q), 32'd0);
      chk("abort_r", 32'(reg_r), 32'd0);
      chk("abort_b", 32'(reg_b), 32'd0);
      chk("abort_count", 32'(count_out), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      got = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (done) got = 1;
      end
      chk("abort_no_done", 32'(got), 32'd0);
      do_div(4'd5, 4'd13, 4'd2, 4'd3);

      // start held high; operands change after the first acceptance
      start = 1'b1; data_in_1 = 4'd2; data_in_2 = 4'd15;
      @(posedge clk); #1;
      data_in_1 = 4'd3; data_in_2 = 4'd13;
      first = -1; second = -1; npulses = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (done) begin
            npulses++;
            if (first < 0) begin
               first = i;
               chk("b2b_q1", 32'(reg_q), 32'd7);
               chk("b2b_r1", 32'(reg_r), 32'd1);
            end else if (second < 0) begin
               second = i;
               chk("b2b_q2", 32'(reg_q), 32'd4);
               chk("b2b_r2", 32'(reg_r), 32'd1);
            end
         end
      end
      start = 1'b0;
      chk("b2b_first_latency", 32'(first), 32'd5);
      chk("b2b_gap", 32'(second - first), 32'd6);
      chk("b2b_pulses", 32'(npulses), 32'd3);
      repeat (10) @(posedge clk);
      #1;

      for (int i = 0; i < 40; i++) begin
         rb = 4'($urandom_range(0, 15));
         ra = 4'($urandom_range(0, 15));
         model(rb, ra, mq, mr);
         do_div(rb, ra, mq, mr);
      end

      div8(8'd7, 8'd200);
      chk("w8_q_200_7", 32'(reg_q8), 32'd28);
      chk("w8_r_200_7", 32'(reg_r8), 32'd4);
      div8(8'd255, 8'd254);
      chk("w8_q_254_255", 32'(reg_q8), 32'd0);
      chk("w8_r_254_255", 32'(reg_r8), 32'd254);
      for (int i = 0; i < 10; i++) div8(8'($urandom_range(1, 255)), 8'($urandom_range(0, 255)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
